// File: rtl/uart_pkg.sv
// uart_pkg: shared frame constants, timeout default and FSM encoding for the UART frame parser
package uart_pkg;
  localparam logic [7:0] _HDR0 = 8'h55;
  localparam logic [7:0] _HDR1 = 8'hAA;
  localparam logic [7:0] _TAIL = 8'h0D;
  localparam int _DATA_NUM = 11;
  localparam int CLK_HZ = 50_000_000;
  localparam int _TIMEOUT_CYC = CLK_HZ / 1000;
  typedef enum logic [2:0] {IDLE, HDR1, FUNC, DATA, CHK, TAIL} state_t;
endpackage

// File: rtl/uart_byte_timeout.sv
// uart_byte_timeout: inter-byte watchdog; cleared by each byte, counts while enabled, saturates at LIMIT-1
module uart_byte_timeout #(
  parameter int LIMIT = 50000
) (
  input  logic clk_50M,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(LIMIT);
  logic [W-1:0] cnt;
  logic at_lim;
  assign at_lim = cnt == W'(LIMIT - 1);
  assign tc = en && !clr && at_lim;
  // a byte always restarts the window; otherwise count up while enabled and hold at the limit
  always_ff @(posedge clk_50M or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !at_lim) cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_pack_parser.sv
// uart_pack_parser: header-synchronised frame assembler feeding the register mapper; define PACK_CHECKSUM_EN to require a checksum byte before the tail
module uart_pack_parser
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYC = _TIMEOUT_CYC
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] func_reg,
  output logic [7:0] rev_data1,
  output logic [7:0] rev_data2,
  output logic [7:0] rev_data3,
  output logic [7:0] rev_data4,
  output logic [7:0] rev_data5,
  output logic [7:0] rev_data6,
  output logic [7:0] rev_data7,
  output logic [7:0] rev_data8,
  output logic [7:0] rev_data9,
  output logic [7:0] rev_data10,
  output logic [7:0] rev_data11,
  output logic       pack_done,
  output logic       frame_err,
  output logic       busy
);
  state_t st, nxt;
  logic [7:0] sh_func;
  logic [7:0] shadow [_DATA_NUM];
  logic [7:0] out_data [_DATA_NUM];
  logic [3:0] idx;
  logic last, tc, done_set, err_set;
`ifdef PACK_CHECKSUM_EN
  logic [7:0] sum;
`endif
  assign last = idx == 4'(_DATA_NUM - 1);
  assign busy = st != IDLE;
  uart_byte_timeout #(.LIMIT(TIMEOUT_CYC)) u_to (
    .clk_50M(clk_50M),
    .rst(rst),
    .clr(rx_done),
    .en(busy),
    .tc(tc)
  );
  // state register
  always_ff @(posedge clk_50M or posedge rst)
    if (rst) st <= IDLE;
    else st <= nxt;
  // next state and publish/error decisions; a byte takes priority over a coincident timeout
  always_comb begin
    nxt = st;
    done_set = 1'b0;
    err_set = 1'b0;
    if (rx_done)
      case (st)
        IDLE: nxt = rx_data == _HDR0 ? HDR1 : IDLE;
        HDR1: nxt = rx_data == _HDR1 ? FUNC : rx_data == _HDR0 ? HDR1 : IDLE;
        FUNC: nxt = DATA;
`ifdef PACK_CHECKSUM_EN
        DATA: nxt = last ? CHK : DATA;
        CHK: begin
          nxt = rx_data == sum ? TAIL : IDLE;
          err_set = rx_data != sum;
        end
`else
        DATA: nxt = last ? TAIL : DATA;
`endif
        TAIL: begin
          nxt = IDLE;
          done_set = rx_data == _TAIL;
          err_set = rx_data != _TAIL;
        end
        default: nxt = IDLE;
      endcase
    else if (tc) begin
      nxt = IDLE;
      err_set = 1'b1;
    end
  end
  // shadow capture, registered pulses, and copy of the shadow to the outputs on a good tail
  always_ff @(posedge clk_50M or posedge rst)
    if (rst) begin
      sh_func <= '0;
      idx <= '0;
      shadow <= '{default: '0};
      out_data <= '{default: '0};
      func_reg <= '0;
      pack_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      pack_done <= done_set;
      frame_err <= err_set;
      if (rx_done && st == FUNC) begin
        sh_func <= rx_data;
        idx <= '0;
      end
      if (rx_done && st == DATA) begin
        shadow[idx] <= rx_data;
        idx <= idx + 4'd1;
      end
      if (done_set) begin
        func_reg <= sh_func;
        out_data <= shadow;
      end
    end
`ifdef PACK_CHECKSUM_EN
  // running modulo-256 sum over FUNC and the payload
  always_ff @(posedge clk_50M or posedge rst)
    if (rst) sum <= '0;
    else if (rx_done && st == FUNC) sum <= rx_data;
    else if (rx_done && st == DATA) sum <= sum + rx_data;
`endif
  assign rev_data1 = out_data[0];
  assign rev_data2 = out_data[1];
  assign rev_data3 = out_data[2];
  assign rev_data4 = out_data[3];
  assign rev_data5 = out_data[4];
  assign rev_data6 = out_data[5];
  assign rev_data7 = out_data[6];
  assign rev_data8 = out_data[7];
  assign rev_data9 = out_data[8];
  assign rev_data10 = out_data[9];
  assign rev_data11 = out_data[10];
endmodule

// File: tb/tb_uart_pack_parser.sv
// tb_uart_pack_parser: directed frames through the parser with immediate-assertion checks
module tb_uart_pack_parser;
  logic clk_50M = 1'b0;
  logic rst = 1'b1;
  logic rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] func_reg, rev_data1, rev_data2, rev_data3, rev_data4, rev_data5, rev_data6;
  logic [7:0] rev_data7, rev_data8, rev_data9, rev_data10, rev_data11;
  logic pack_done, frame_err, busy;
  int n_cmp = 0, n_bad = 0, n_done = 0, n_err = 0, n_dbl = 0;
  int d0, e0, k;
  logic pulse_q = 1'b0;
  logic [7:0] pay [11];

  uart_pack_parser dut (
    .clk_50M(clk_50M), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .func_reg(func_reg), .rev_data1(rev_data1), .rev_data2(rev_data2), .rev_data3(rev_data3),
    .rev_data4(rev_data4), .rev_data5(rev_data5), .rev_data6(rev_data6), .rev_data7(rev_data7),
    .rev_data8(rev_data8), .rev_data9(rev_data9), .rev_data10(rev_data10), .rev_data11(rev_data11),
    .pack_done(pack_done), .frame_err(frame_err), .busy(busy)
  );

  always #10 clk_50M = ~clk_50M;

  always @(posedge clk_50M) begin
    if (pack_done) n_done <= n_done + 1;
    if (frame_err) n_err <= n_err + 1;
    if ((pack_done || frame_err) && pulse_q) n_dbl <= n_dbl + 1;
    pulse_q <= pack_done || frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_50M);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk_50M);
    rx_done = 1'b0;
  endtask

  task automatic sb(input logic [7:0] b);
    send_byte(b);
    repeat (8) @(negedge clk_50M);
  endtask

  task automatic send_body(input logic [7:0] f, input logic [7:0] tl, input logic bad_chk);
    logic [7:0] s;
    s = f;
    sb(f);
    for (int i = 0; i < 11; i++) begin
      sb(pay[i]);
      s = s + pay[i];
    end
`ifdef PACK_CHECKSUM_EN
    sb(bad_chk ? s + 8'h01 : s);
`else
    if (bad_chk) s = 8'h00;
`endif
    send_byte(tl);
  endtask

  initial begin
    pay = '{8'h02, 8'h11, 8'h05, 8'h00, 8'h64, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    repeat (3) @(negedge clk_50M);
    rst = 1'b0;
    @(negedge clk_50M);
    chk("rst_func", func_reg, 8'h00);
    chk("rst_d1", rev_data1, 8'h00);
    chk("rst_d11", rev_data11, 8'h00);
    chk("rst_done", pack_done, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // valid reference frame
    sb(8'h55);
    sb(8'hAA);
    chk("a_busy", busy, 1'b1);
    send_body(8'h01, 8'h0D, 1'b0);
    chk("a_done", pack_done, 1'b1);
    chk("a_err", frame_err, 1'b0);
    chk("a_busy_end", busy, 1'b0);
    chk("a_func", func_reg, 8'h01);
    chk("a_d1", rev_data1, 8'h02);
    chk("a_d2", rev_data2, 8'h11);
    chk("a_d5", rev_data5, 8'h64);
    chk("a_d7", rev_data7, 8'hDE);
    chk("a_d10", rev_data10, 8'hEF);
    chk("a_d11", rev_data11, 8'h00);
    @(negedge clk_50M);
    chk("a_done_1cyc", pack_done, 1'b0);

`ifdef PACK_CHECKSUM_EN
    // corrupted checksum: error, nothing published
    d0 = n_done;
    e0 = n_err;
    sb(8'h55);
    sb(8'hAA);
    send_body(8'h07, 8'h0D, 1'b1);
    repeat (2) @(negedge clk_50M);
    chk("c_err_cnt", n_err - e0, 1);
    chk("c_done_cnt", n_done - d0, 0);
    chk("c_func_kept", func_reg, 8'h01);
    chk("c_busy", busy, 1'b0);
`endif

    // stray bytes then a resynchronising header
    pay = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9, 8'hB0, 8'hB1};
    e0 = n_err;
    sb(8'h13);
    sb(8'h55);
    sb(8'h7F);
    sb(8'h55);
    sb(8'h55);
    sb(8'hAA);
    send_body(8'h22, 8'h0D, 1'b0);
    chk("r_done", pack_done, 1'b1);
    chk("r_func", func_reg, 8'h22);
    chk("r_d4", rev_data4, 8'hA4);
    chk("r_d11", rev_data11, 8'hB1);
    repeat (2) @(negedge clk_50M);
    chk("r_no_err", n_err - e0, 0);

    // inter-byte timeout after D5
    d0 = n_done;
    sb(8'h55);
    sb(8'hAA);
    sb(8'h33);
    for (int i = 0; i < 4; i++) sb(pay[i]);
    send_byte(pay[4]);
    chk("t_busy", busy, 1'b1);
    for (k = 1; k <= 50010; k++) begin
      @(negedge clk_50M);
      if (frame_err) break;
    end
    chk("t_err_seen", frame_err, 1'b1);
    chk("t_err_when", (k >= 49999 && k <= 50001), 1'b1);
    chk("t_busy_end", busy, 1'b0);
    @(negedge clk_50M);
    chk("t_err_1cyc", frame_err, 1'b0);
    chk("t_func_kept", func_reg, 8'h22);
    sb(8'h55);
    sb(8'hAA);
    send_body(8'h33, 8'h0D, 1'b0);
    chk("t_recover_done", pack_done, 1'b1);
    chk("t_recover_func", func_reg, 8'h33);
    repeat (2) @(negedge clk_50M);
    chk("t_done_cnt", n_done - d0, 1);

    // reset in the middle of a frame
    pay = '{8'h02, 8'h11, 8'h05, 8'h00, 8'h64, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    d0 = n_done;
    sb(8'h55);
    sb(8'hAA);
    sb(8'h44);
    for (int i = 0; i < 7; i++) sb(pay[i]);
    @(negedge clk_50M);
    rst = 1'b1;
    #1;
    chk("x_func", func_reg, 8'h00);
    chk("x_d1", rev_data1, 8'h00);
    chk("x_busy", busy, 1'b0);
    @(negedge clk_50M);
    rst = 1'b0;
    for (int i = 7; i < 11; i++) sb(pay[i]);
`ifdef PACK_CHECKSUM_EN
    sb(8'h00);
`endif
    sb(8'h0D);
    chk("x_ignored_done", n_done - d0, 0);
    chk("x_ignored_busy", busy, 1'b0);
    chk("x_func_zero", func_reg, 8'h00);

    // wrong tail, then a frame starting on the very next byte
    sb(8'h55);
    sb(8'hAA);
    send_body(8'h5A, 8'h0A, 1'b0);
    chk("w_err", frame_err, 1'b1);
    chk("w_no_done", pack_done, 1'b0);
    chk("w_func_kept", func_reg, 8'h00);
    sb(8'h55);
    sb(8'hAA);
    send_body(8'h66, 8'h0D, 1'b0);
    chk("w_done", pack_done, 1'b1);
    chk("w_func", func_reg, 8'h66);
    chk("w_d7", rev_data7, 8'hDE);
    repeat (2) @(negedge clk_50M);
    chk("no_double_pulse", n_dbl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
